// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/execute controller that steps a 4-bit accumulator CPU through an instruction ROM
// Ports: clk/rst_n (async active-low); start pulse; imem_req/imem_addr/imem_valid/imem_data fetch
// handshake; exe_opcode/exe_operand to the execution unit, exe_result back; acc, pc, busy,
// halted, fetch_err status. Optional EXEC_SEQ_SINGLE_STEP_EN adds input step and a PAUSE state.
module exec_sequencer #(
  parameter int PC_W     = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef EXEC_SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [7:0]      imem_data,
  output logic [3:0]      exe_opcode,
  output logic [3:0]      exe_operand,
  input  logic [3:0]      exe_result,
  output logic [3:0]      acc,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            fetch_err
);
  localparam int WW = $clog2(MAX_WAIT + 2);
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALT,
`ifdef EXEC_SEQ_SINGLE_STEP_EN
    S_PAUSE,
`endif
    S_ERR
  } state_t;
  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [3:0]      r_acc, w_acc_nx;
  logic [7:0]      r_ir;
  logic [WW-1:0]   r_wait;
  logic            w_idle, w_last_wait;
  assign w_idle      = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERR);
  assign w_last_wait = (r_wait == WW'(MAX_WAIT));
  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign acc         = r_acc;
  // The instruction register feeds the unit directly, so the operands hold between instructions.
  assign exe_opcode  = r_ir[7:4];
  assign exe_operand = r_ir[3:0];
  assign busy        = !w_idle;
  assign halted      = (r_state == S_HALT);
  assign fetch_err   = (r_state == S_ERR);
  assign w_acc_nx = (exe_opcode == 4'h0) ? r_acc + exe_result :
                    (exe_opcode == 4'h1) ? r_acc - exe_result :
                    (exe_opcode == 4'h2) ? r_acc & exe_result :
                    (exe_opcode == 4'h3) ? r_acc | exe_result : r_acc;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT, S_ERR: w_next = start ? S_FETCH : r_state;
      S_FETCH: w_next = imem_valid ? ((imem_data[7:4] == 4'hF) ? S_HALT : S_EXEC) :
                        w_last_wait ? S_ERR : S_FETCH;
      S_EXEC: w_next = S_WB;
`ifdef EXEC_SEQ_SINGLE_STEP_EN
      S_WB: w_next = S_PAUSE;
      S_PAUSE: w_next = step ? S_FETCH : S_PAUSE;
`else
      S_WB: w_next = S_FETCH;
`endif
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_acc  <= '0;
      r_ir   <= '0;
      r_wait <= '0;
    end else if (w_idle) begin
      if (start) begin
        r_pc   <= '0;
        r_acc  <= '0;
        r_wait <= '0;
      end
    end else if (r_state == S_FETCH) begin
      if (imem_valid) begin
        r_ir   <= imem_data;
        r_wait <= '0;
      end else if (!w_last_wait) begin
        r_wait <= r_wait + 1'b1;
      end
    end else if (r_state == S_WB) begin
      r_acc <= w_acc_nx;
      r_pc  <= r_pc + 1'b1;
    end
  end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: scoreboard bench for exec_sequencer with a ROM responder and pass-through execution unit
module tb_exec_sequencer;
  localparam int PW = 2;
  logic          clk = 0, rst_n = 0, start = 0, imem_valid = 0;
  logic [7:0]    imem_data = '0;
  logic [3:0]    exe_result;
  logic          imem_req, busy, halted, fetch_err;
  logic [PW-1:0] imem_addr, pc;
  logic [3:0]    exe_opcode, exe_operand, acc;
  int            checks = 0, failures = 0;
  logic [7:0]    rom [4];
  logic [3:0]    sb [$];
  int            wb_t [$];
  logic [PW-1:0] addr_log [$];
`ifdef EXEC_SEQ_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  exec_sequencer #(.PC_W(PW), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef EXEC_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .exe_opcode(exe_opcode), .exe_operand(exe_operand), .exe_result(exe_result),
    .acc(acc), .pc(pc), .busy(busy), .halted(halted), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  // Execution unit stand-in: result is the operand itself.
  assign exe_result = exe_operand;
  function automatic logic [3:0] model(input logic [3:0] a, input logic [7:0] ins);
    case (ins[7:4])
      4'h0: return a + ins[3:0];
      4'h1: return a - ins[3:0];
      4'h2: return a & ins[3:0];
      4'h3: return a | ins[3:0];
      default: return a;
    endcase
  endfunction
  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask
  // Pulses start, serves fetches after dly idle FETCH cycles, and checks acc at each WB.
  // Stops at HALT, or one cycle after the stop_after-th fetch when stop_after > 0.
  task automatic run(input int dly, input int stop_after);
    int w = 0, cd = 0, n = 0, cyc = 0;
    logic [3:0] m = '0;
    logic [3:0] e;
    sb.delete(); wb_t.delete(); addr_log.delete();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    while (cyc < 400) begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          e = sb.pop_front();
          wb_t.push_back(cyc);
          checks++;
          if (acc !== e) begin failures++; $display("FAIL wb_acc: got %h want %h at cycle %0d", acc, e, cyc); end
        end
      end
      if (halted) break;
      imem_valid = 0;
      if (imem_req) begin
        if (w >= dly) begin
          imem_valid = 1;
          imem_data = rom[imem_addr];
          addr_log.push_back(imem_addr);
          w = 0;
          n++;
          if (imem_data[7:4] != 4'hF) begin m = model(m, imem_data); sb.push_back(m); cd = 3; end
        end else w++;
      end
      @(negedge clk); cyc++;
      if (stop_after > 0 && n == stop_after) break;
    end
    imem_valid = 0;
    checks++;
    if (cyc >= 400) begin failures++; $display("FAIL run_timeout: got %0d cycles want <400", cyc); end
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({acc, pc, exe_opcode, exe_operand} !== '0) begin
      failures++; $display("FAIL reset_regs: got %h want 0", {acc, pc, exe_opcode, exe_operand});
    end
    checks++;
    if ({imem_req, busy, halted, fetch_err} !== 4'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 0000", {imem_req, busy, halted, fetch_err});
    end
    rst_n = 1;
  endtask
  task automatic test_basic;
    load(8'h03, 8'h05, 8'h12, 8'hF0);
    run(0, 0);
    checks++;
    if ({halted, busy, pc, acc} !== {1'b1, 1'b0, 2'd3, 4'h6}) begin
      failures++; $display("FAIL basic_end: got h%b b%b pc%0d acc%h want h1 b0 pc3 acc6", halted, busy, pc, acc);
    end
    checks++;
    if (wb_t.size() != 3 || wb_t[1] - wb_t[0] != 3 || wb_t[2] - wb_t[1] != 3) begin
      failures++; $display("FAIL basic_spacing: got %0d writebacks with wrong spacing want 3 at 3 cycles", wb_t.size());
    end
  endtask
  task automatic test_logic;
    load(8'h0F, 8'h26, 8'h39, 8'hF0);
    run(0, 0);
    checks++;
    if ({halted, acc} !== {1'b1, 4'hF}) begin
      failures++; $display("FAIL logic_end: got h%b acc%h want h1 accf", halted, acc);
    end
  endtask
  task automatic test_wrap;
    load(8'h09, 8'h09, 8'h1B, 8'hF0);
    run(0, 0);
    checks++;
    if (acc !== 4'h7) begin failures++; $display("FAIL add_wrap: got %h want 7", acc); end
    load(8'h11, 8'hF0, 8'h00, 8'h00);
    run(0, 0);
    checks++;
    if ({acc, pc} !== {4'hF, 2'd1}) begin failures++; $display("FAIL sub_underflow: got acc%h pc%0d want accf pc1", acc, pc); end
  endtask
  task automatic test_timeout;
    int cnt = 0;
    imem_valid = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 40 && !fetch_err; i++) begin
      if (imem_req) cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 16) begin failures++; $display("FAIL timeout_req_cycles: got %0d want 16", cnt); end
    checks++;
    if ({fetch_err, busy, imem_req} !== 3'b100) begin
      failures++; $display("FAIL timeout_flags: got %b want 100", {fetch_err, busy, imem_req});
    end
    load(8'h03, 8'h05, 8'h12, 8'hF0);
    run(0, 0);
    checks++;
    if ({fetch_err, halted, acc} !== {1'b0, 1'b1, 4'h6}) begin
      failures++; $display("FAIL err_restart: got e%b h%b acc%h want e0 h1 acc6", fetch_err, halted, acc);
    end
  endtask
  task automatic test_wait_reset;
    load(8'h03, 8'h05, 8'h12, 8'hF0);
    run(4, 0);
    checks++;
    if (acc !== 4'h6 || wb_t.size() != 3 || wb_t[1] - wb_t[0] != 7 || wb_t[2] - wb_t[1] != 7) begin
      failures++; $display("FAIL wait_states: got acc%h with %0d writebacks want acc6 at 7 cycles", acc, wb_t.size());
    end
    run(0, 2);
    checks++;
    if ({acc, pc} !== {4'h3, 2'd1}) begin failures++; $display("FAIL pre_reset: got acc%h pc%0d want acc3 pc1", acc, pc); end
    rst_n = 0;
    #1;
    checks++;
    if ({acc, pc, imem_req, busy, exe_opcode} !== '0) begin
      failures++; $display("FAIL async_reset: got %h want 0", {acc, pc, imem_req, busy, exe_opcode});
    end
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_pc_wrap;
    logic [PW-1:0] ea;
    load(8'h40, 8'h40, 8'h40, 8'h40);
    run(0, 6);
    checks++;
    if (addr_log.size() != 6) begin failures++; $display("FAIL wrap_count: got %0d fetches want 6", addr_log.size()); end
    for (int i = 0; i < 6 && i < addr_log.size(); i++) begin
      ea = PW'(i % 4);
      checks++;
      if (addr_log[i] !== ea) begin failures++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, addr_log[i], ea); end
    end
    checks++;
    if ({acc, fetch_err} !== 5'b0) begin failures++; $display("FAIL wrap_state: got acc%h e%b want acc0 e0", acc, fetch_err); end
    rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_logic;
    test_wrap;
    test_timeout;
    test_wait_reset;
    test_pc_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
